// File: rtl/lstm_window_feeder_if.sv
// Stream-in / result-out handshake bundle for lstm_window_feeder.
// The feeder sits on the slave side: it consumes samples and produces results.
interface lstm_window_feeder_if #(
    parameter int WIDTH = 18
);
    // sample stream towards the feeder
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    // per-window result stream out of the feeder
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_c;
    logic [WIDTH-1:0] m_h;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_c, m_h
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_c, m_h
    );
endinterface

// File: rtl/lstm_window_feeder.sv
// Packs a Q6.11 sample stream into 4-step windows for lstm_4step_pipeline,
// carries c4/h4 back as c0/h0 for the next window and reports each window's
// (c4, h4) on a result handshake. Data passes through bit-exact.
module lstm_window_feeder #(
    parameter int WIDTH = 18,
    parameter int FRAC  = 11,
    parameter int LAT   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lstm_window_feeder_if.slave  bus,
    input  logic                 clr_state,
    output logic [WIDTH-1:0]     x1,
    output logic [WIDTH-1:0]     x2,
    output logic [WIDTH-1:0]     x3,
    output logic [WIDTH-1:0]     x4,
    output logic [WIDTH-1:0]     c0,
    output logic [WIDTH-1:0]     h0,
    input  logic [WIDTH-1:0]     c4_in,
    input  logic [WIDTH-1:0]     h4_in,
    output logic                 busy
);

    // No LAUNCH state: the window is copied to x1..x4 on its closing edge.
    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    // Last wait-count value; FRAC is descriptive only and enters with weight zero.
    localparam logic [7:0] WAIT_LAST = 8'(LAT - 1 + 0 * FRAC);

    logic [1:0]            state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic [2:0][WIDTH-1:0] stage_q, stage_d;
    logic [3:0][WIDTH-1:0] x_q, x_d;
    logic [3:0][WIDTH-1:0] win_s;
    logic [WIDTH-1:0]      c0_q, c0_d, h0_q, h0_d;
    logic [WIDTH-1:0]      m_c_q, m_c_d, m_h_q, m_h_d;
    logic                  m_valid_q, m_valid_d;
    logic                  last_q, last_d;
    logic                  pend_q, pend_d;
    logic                  s_ready_q, s_ready_d;
    logic                  busy_q, busy_d;
    logic                  accept_s;

    assign accept_s = bus.s_valid && s_ready_q;

    // Window as it would look if the current sample closes it: earlier slots
    // from staging, the incoming sample at slot[count], zeros above it.
    always_comb begin
        win_s[0] = (cnt_q == 2'd0) ? bus.s_data : stage_q[0];
        if (cnt_q == 2'd1) begin
            win_s[1] = bus.s_data;
        end else if (cnt_q > 2'd1) begin
            win_s[1] = stage_q[1];
        end else begin
            win_s[1] = '0;
        end
        if (cnt_q == 2'd2) begin
            win_s[2] = bus.s_data;
        end else if (cnt_q > 2'd2) begin
            win_s[2] = stage_q[2];
        end else begin
            win_s[2] = '0;
        end
        win_s[3] = (cnt_q == 2'd3) ? bus.s_data : '0;
    end

    // Sequencer: fill the window, wait out the core latency, hold the result.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        stage_d   = stage_q;
        x_d       = x_q;
        c0_d      = c0_q;
        h0_d      = h0_q;
        m_c_d     = m_c_q;
        m_h_d     = m_h_q;
        m_valid_d = m_valid_q;
        last_d    = last_q;
        pend_d    = pend_q;
        case (state_q)
            ST_FILL: begin
                if (clr_state) begin
                    c0_d = '0;
                    h0_d = '0;
                end else begin
                    c0_d = c0_q;
                    h0_d = h0_q;
                end
                if (accept_s) begin
                    if ((cnt_q == 2'd3) || bus.s_last) begin
                        x_d     = win_s;
                        stage_d = '0;
                        cnt_d   = 2'd0;
                        wcnt_d  = 8'd0;
                        last_d  = bus.s_last;
                        state_d = ST_WAIT;
                    end else begin
                        stage_d[cnt_q] = bus.s_data;
                        cnt_d          = cnt_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WAIT: begin
                if (clr_state) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                if (wcnt_q == WAIT_LAST) begin
                    // capture edge: a clear arriving right now still applies
                    m_c_d     = c4_in;
                    m_h_d     = h4_in;
                    m_valid_d = 1'b1;
                    if (last_q || pend_q || clr_state) begin
                        c0_d = '0;
                        h0_d = '0;
                    end else begin
                        c0_d = c4_in;
                        h0_d = h4_in;
                    end
                    pend_d  = 1'b0;
                    state_d = ST_OUT;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            ST_OUT: begin
                if (clr_state) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                if (m_valid_q && bus.m_ready) begin
                    m_valid_d = 1'b0;
                    cnt_d     = 2'd0;
                    state_d   = ST_FILL;
                end else begin
                    m_valid_d = m_valid_q;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
        s_ready_d = (state_d == ST_FILL);
        busy_d    = (state_d != ST_FILL);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            cnt_q     <= 2'd0;
            wcnt_q    <= 8'd0;
            stage_q   <= '0;
            x_q       <= '0;
            c0_q      <= '0;
            h0_q      <= '0;
            m_c_q     <= '0;
            m_h_q     <= '0;
            m_valid_q <= 1'b0;
            last_q    <= 1'b0;
            pend_q    <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            stage_q   <= stage_d;
            x_q       <= x_d;
            c0_q      <= c0_d;
            h0_q      <= h0_d;
            m_c_q     <= m_c_d;
            m_h_q     <= m_h_d;
            m_valid_q <= m_valid_d;
            last_q    <= last_d;
            pend_q    <= pend_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
        end
    end

    assign x1          = x_q[0];
    assign x2          = x_q[1];
    assign x3          = x_q[2];
    assign x4          = x_q[3];
    assign c0          = c0_q;
    assign h0          = h0_q;
    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_c     = m_c_q;
    assign bus.m_h     = m_h_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_lstm_window_feeder.sv
// Self-checking bench for lstm_window_feeder with a delayed-add core stub.
module tb_lstm_window_feeder;

    localparam int W   = 18;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr_state = 1'b0;
    logic [W-1:0] x1, x2, x3, x4, c0, h0, c4_in, h4_in;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // reference model carried state
    logic [W-1:0] mdl_c = '0;
    logic [W-1:0] mdl_h = '0;

    always #5 clk = ~clk;

    lstm_window_feeder_if #(.WIDTH(W)) bus ();

    lstm_window_feeder #(.WIDTH(W), .FRAC(11), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clr_state(clr_state),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4), .c0(c0), .h0(h0),
        .c4_in(c4_in), .h4_in(h4_in), .busy(busy)
    );

    // Core stub: outputs are only correct once its inputs have been stable
    // for LAT-1 edges, i.e. they become readable on the LAT-th edge.
    logic [6*W-1:0] snap = '0;
    int             age  = 0;
    logic [W-1:0]   sum_c, sum_h;
    assign sum_c = x1 + x2 + x3 + x4 + c0;
    assign sum_h = x4 + h0;
    always @(posedge clk) begin
        if ({x1, x2, x3, x4, c0, h0} != snap) begin
            snap <= {x1, x2, x3, x4, c0, h0};
            age  <= 1;
        end else if (age < 1000) begin
            age <= age + 1;
        end
    end
    assign c4_in = (age >= LAT - 1) ? sum_c : (sum_c ^ 18'h2AAAA);
    assign h4_in = (age >= LAT - 1) ? sum_h : (sum_h ^ 18'h15555);

    // Behavioural window model: pad to 4, add, then carry or clear state.
    function automatic void mdl_window(input logic [W-1:0] s[$], input bit clear,
                                       output logic [3:0][W-1:0] ex,
                                       output logic [W-1:0] ec, output logic [W-1:0] eh);
        ex = '0;
        foreach (s[i]) if (i < 4) ex[i] = s[i];
        ec = mdl_c;
        for (int i = 0; i < 4; i++) ec = ec + ex[i];
        eh = ex[3] + mdl_h;
        mdl_c = clear ? '0 : ec;
        mdl_h = clear ? '0 : eh;
    endfunction

    // Offer one sample (called at a negedge); returns at the negedge after acceptance.
    task automatic put(input logic [W-1:0] d, input logic l);
        int t;
        t = 0;
        bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = l;
        while (!bus.s_ready && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL put_ready: s_ready=%b after %0d cycles, want 1", bus.s_ready, t);
        end
        @(negedge clk);
        bus.s_valid = 1'b0; bus.s_data = W'($urandom); bus.s_last = 1'b0;
    endtask

    // Feed a window with random idle gaps; ox is x1..x4 right after closing.
    task automatic feed(input logic [W-1:0] s[$], input logic last_on_final, input int max_gap,
                        output logic [3:0][W-1:0] ox);
        foreach (s[i]) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            put(s[i], (i == s.size() - 1) ? last_on_final : 1'b0);
        end
        ox = {x4, x3, x2, x1};
    endtask

    // Wait for the result (optional clr pulse), then consume after ready_delay cycles.
    task automatic collect(input int clr_at, input int ready_delay, output int lat,
                           output logic [3:0][W-1:0] ovx,
                           output logic [W-1:0] oc, output logic [W-1:0] oh,
                           output logic ovalid_after,
                           output logic [W-1:0] oc0, output logic [W-1:0] oh0);
        int k;
        k = 0;
        while (!bus.m_valid && k < 40) begin
            clr_state = (k + 1 == clr_at);
            @(negedge clk);
            k++;
        end
        clr_state = 1'b0;
        lat = bus.m_valid ? k : -1;
        ovx = {x4, x3, x2, x1};
        oc = bus.m_c; oh = bus.m_h;
        repeat (ready_delay) @(negedge clk);
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        ovalid_after = bus.m_valid;
        oc0 = c0; oh0 = h0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
        #1;
        checks++;
        if ({x1, x2, x3, x4, c0, h0, bus.m_c, bus.m_h} !== '0 || bus.m_valid !== 1'b0 ||
            bus.s_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: x=%h c0=%h h0=%h mv=%b sr=%b busy=%b, want all 0",
                     {x1, x2, x3, x4}, c0, h0, bus.m_valid, bus.s_ready, busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b0) begin
            errors++; $display("FAIL reset_hold_ready: s_ready=%b want 0", bus.s_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1 || busy !== 1'b0 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: sr=%b busy=%b mv=%b want 1 0 0", bus.s_ready, busy, bus.m_valid);
        end
    endtask

    // One full window with m_ready asserted as soon as the result shows up.
    task automatic test_window(input string nm, input logic [W-1:0] s[$], input logic last,
                               input logic [W-1:0] want_c, input logic [W-1:0] want_h);
        logic [3:0][W-1:0] ox, ovx, ex;
        logic [W-1:0] ec, eh, oc, oh, oc0, oh0;
        logic va;
        int lat;
        mdl_window(s, last, ex, ec, eh);
        feed(s, last, 0, ox);
        collect(0, 0, lat, ovx, oc, oh, va, oc0, oh0);
        checks++;
        if (ox !== ex) begin errors++; $display("FAIL %s_x: got %h want %h", nm, ox, ex); end
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, LAT); end
        checks++;
        if (oc !== want_c || oh !== want_h || oc !== ec || oh !== eh) begin
            errors++; $display("FAIL %s_result: m_c=%0d m_h=%0d want %0d %0d", nm, oc, oh, want_c, want_h);
        end
        checks++;
        if (va !== 1'b0 || oc0 !== mdl_c || oh0 !== mdl_h) begin
            errors++; $display("FAIL %s_carry: mv=%b c0=%0d h0=%0d want 0 %0d %0d", nm, va, oc0, oh0, mdl_c, mdl_h);
        end
    endtask

    task automatic test_backpressure;
        logic [3:0][W-1:0] ox, ex;
        logic [W-1:0] ec, eh, mc0, mh0;
        logic [W-1:0] s[$];
        int k;
        s = '{18'd100, 18'd200, 18'd300, 18'd400};
        mdl_window(s, 1'b0, ex, ec, eh);
        feed(s, 1'b0, 0, ox);
        k = 0;
        while (!bus.m_valid && k < 40) begin @(negedge clk); k++; end
        checks++;
        if (k !== LAT || bus.m_c !== ec || bus.m_h !== eh) begin
            errors++; $display("FAIL bp_first: lat=%0d m_c=%0d m_h=%0d want %0d %0d %0d", k, bus.m_c, bus.m_h, LAT, ec, eh);
        end
        mc0 = bus.m_c; mh0 = bus.m_h;
        for (int i = 0; i < 10; i++) begin
            bus.s_valid = 1'b1; bus.s_data = W'($urandom); bus.s_last = 1'($urandom);
            @(negedge clk);
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_c !== mc0 || bus.m_h !== mh0 ||
                bus.s_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: cyc %0d mv=%b m_c=%0d m_h=%0d sr=%b busy=%b want 1 %0d %0d 0 1",
                         i, bus.m_valid, bus.m_c, bus.m_h, bus.s_ready, busy, mc0, mh0);
            end
        end
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1 || busy !== 1'b0 || c0 !== mdl_c || h0 !== mdl_h) begin
            errors++;
            $display("FAIL bp_release: mv=%b sr=%b busy=%b c0=%0d h0=%0d want 0 1 0 %0d %0d",
                     bus.m_valid, bus.s_ready, busy, c0, h0, mdl_c, mdl_h);
        end
    endtask

    task automatic test_clr_wait;
        logic [3:0][W-1:0] ox, ovx, ex;
        logic [W-1:0] ec, eh, oc, oh, oc0, oh0;
        logic [W-1:0] s[$];
        logic va;
        int lat;
        s = '{18'd7, 18'd8, 18'd9, 18'd10};
        mdl_window(s, 1'b1, ex, ec, eh);
        feed(s, 1'b0, 0, ox);
        collect(2, 1, lat, ovx, oc, oh, va, oc0, oh0);
        checks++;
        if (lat !== LAT || oc !== ec || oh !== eh) begin
            errors++; $display("FAIL clrw_result: lat=%0d m_c=%0d m_h=%0d want %0d %0d %0d", lat, oc, oh, LAT, ec, eh);
        end
        checks++;
        if (oc0 !== '0 || oh0 !== '0) begin
            errors++; $display("FAIL clrw_state: c0=%0d h0=%0d want 0 0", oc0, oh0);
        end
        test_window("clrw_next", '{18'd1, 18'd2, 18'd3, 18'd4}, 1'b0, 18'd10, 18'd4);
    endtask

    task automatic test_clr_fill;
        checks++;
        if (c0 !== mdl_c || h0 !== mdl_h || c0 === '0) begin
            errors++; $display("FAIL clrf_pre: c0=%0d h0=%0d want %0d %0d (nonzero)", c0, h0, mdl_c, mdl_h);
        end
        clr_state = 1'b1;
        @(negedge clk);
        clr_state = 1'b0;
        mdl_c = '0; mdl_h = '0;
        checks++;
        if (c0 !== '0 || h0 !== '0 || bus.s_ready !== 1'b1) begin
            errors++; $display("FAIL clrf_zero: c0=%0d h0=%0d sr=%b want 0 0 1", c0, h0, bus.s_ready);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0][W-1:0] ox;
        feed('{18'd5, 18'd6, 18'd7, 18'd8}, 1'b0, 0, ox);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({x1, x2, x3, x4, c0, h0, bus.m_c, bus.m_h} !== '0 || bus.m_valid !== 1'b0 ||
            bus.s_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: x=%h c0=%h h0=%h mv=%b sr=%b busy=%b want all 0",
                     {x1, x2, x3, x4}, c0, h0, bus.m_valid, bus.s_ready, busy);
        end
        mdl_c = '0; mdl_h = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_release: sr=%b mv=%b busy=%b want 1 0 0", bus.s_ready, bus.m_valid, busy);
        end
        test_window("rstmid_fresh", '{18'd2048, 18'd1024, 18'd512, 18'd2048}, 1'b0, 18'd5632, 18'd2048);
    endtask

    task automatic test_random;
        logic [3:0][W-1:0] ox, ovx, ex;
        logic [W-1:0] ec, eh, oc, oh, oc0, oh0;
        logic [W-1:0] s[$];
        logic va, last;
        int n, clr_at, rd, lat;
        for (int w = 0; w < 30; w++) begin
            n = $urandom_range(1, 4);
            last = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            s.delete();
            for (int i = 0; i < n; i++) s.push_back(W'($urandom));
            clr_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, LAT) : 0;
            rd = $urandom_range(0, 3);
            mdl_window(s, last || (clr_at != 0), ex, ec, eh);
            feed(s, last, 2, ox);
            checks++;
            if (ox !== ex || busy !== 1'b1 || bus.s_ready !== 1'b0) begin
                errors++; $display("FAIL rnd_close w%0d: x=%h busy=%b sr=%b want %h 1 0", w, ox, busy, bus.s_ready, ex);
            end
            collect(clr_at, rd, lat, ovx, oc, oh, va, oc0, oh0);
            checks++;
            if (lat !== LAT || ovx !== ex) begin
                errors++; $display("FAIL rnd_wait w%0d: lat=%0d x=%h want %0d %h", w, lat, ovx, LAT, ex);
            end
            checks++;
            if (oc !== ec || oh !== eh) begin
                errors++; $display("FAIL rnd_result w%0d: m_c=%h m_h=%h want %h %h", w, oc, oh, ec, eh);
            end
            checks++;
            if (va !== 1'b0 || oc0 !== mdl_c || oh0 !== mdl_h) begin
                errors++; $display("FAIL rnd_carry w%0d: mv=%b c0=%h h0=%h want 0 %h %h", w, va, oc0, oh0, mdl_c, mdl_h);
            end
        end
    endtask

    initial begin
        test_reset();
        test_window("basic", '{18'd2048, 18'd1024, 18'd512, 18'd2048}, 1'b0, 18'd5632, 18'd2048);
        test_window("chain", '{18'd2048, 18'd2048, 18'd2048, 18'd2048}, 1'b0, 18'd13824, 18'd4096);
        test_window("early_last", '{18'd2048, 18'd2048}, 1'b1, 18'd17920, 18'd4096);
        test_backpressure();
        test_clr_wait();
        test_clr_fill();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
